// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters plus the memory.
interface mem_arbiter_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16,
  parameter int unsigned LW = 3
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dp_req;
  logic          dp_we;
  logic [AW-1:0] dp_addr;
  logic [LW-1:0] dp_len;
  logic [DW-1:0] dp_wdata;
  logic          dp_ack;
  logic [DW-1:0] dp_rdata;
  logic          dp_done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          mem_write_n;
  logic          mem_read_n;
  logic [DW-1:0] mem_out;

  modport slave (
    input  if_req, if_addr, dp_req, dp_we, dp_addr, dp_len, dp_wdata, mem_out,
    output if_ack, if_rdata, dp_ack, dp_rdata, dp_done, busy,
           mem_addr, mem_in, mem_write_n, mem_read_n
  );

  modport master (
    output if_req, if_addr, dp_req, dp_we, dp_addr, dp_len, dp_wdata, mem_out,
    input  if_ack, if_rdata, dp_ack, dp_rdata, dp_done, busy,
           mem_addr, mem_in, mem_write_n, mem_read_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port (single reads)
// and the data port (read/write bursts of 1..8 beats). It makes one access every
// two cycles, using registered active-low strobes.
// Define MEM_ARB_RR_EN for round-robin arbitration. Without it, the data port has
// fixed priority over fetch.
module mem_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16,
  parameter int unsigned LW = 3
) (
  input logic          clk,
  input logic          proc_rst,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StAccess, StNext} state_e;

  state_e        state_q, state_d;
  logic          win_dp_q, win_dp_d;    // current owner: 1 = data port, 0 = fetch
  logic          we_q, we_d;
  logic [LW-1:0] cnt_q, cnt_d;          // beats remaining after the current one
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_n_q, write_n_d;
  logic          read_n_q, read_n_d;
  logic          if_ack_q, if_ack_d;
  logic          dp_ack_q, dp_ack_d;
  logic          dp_done_q, dp_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dp_rdata_q, dp_rdata_d;
  logic          if_elig, dp_elig, grant_dp;

  // While a port's final ack is showing, its req may still belong to the transfer
  // that just finished. Such a req must not be granted again.
  assign if_elig = bus_io.if_req & ~if_ack_q;
  assign dp_elig = bus_io.dp_req & ~dp_done_q;

`ifdef MEM_ARB_RR_EN
  logic last_dp_q, last_dp_d;

  assign grant_dp = dp_elig & (~if_elig | ~last_dp_q);

  // Remember which port won the most recent grant.
  always_comb begin
    last_dp_d = last_dp_q;
    if (state_q == StIdle && (if_elig || dp_elig)) last_dp_d = grant_dp;
  end

  // Priority pointer register. After reset it reads "data port last".
  always_ff @(posedge clk) begin
    if (proc_rst) last_dp_q <= 1'b1;
    else          last_dp_q <= last_dp_d;
  end
`else
  assign grant_dp = dp_elig;
`endif

  // Sequencer next state: grant, strobe one access, ack, then step through the burst.
  always_comb begin
    state_d    = state_q;
    win_dp_d   = win_dp_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_n_d  = 1'b1;
    read_n_d   = 1'b1;
    if_ack_d   = 1'b0;
    dp_ack_d   = 1'b0;
    dp_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dp_rdata_d = dp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_elig || dp_elig) begin
          state_d  = StAccess;
          win_dp_d = grant_dp;
          if (grant_dp) begin
            we_d      = bus_io.dp_we;
            cnt_d     = bus_io.dp_len;
            addr_d    = bus_io.dp_addr;
            write_n_d = ~bus_io.dp_we;
            read_n_d  = bus_io.dp_we;
            if (bus_io.dp_we) wdata_d = bus_io.dp_wdata;
          end else begin
            we_d     = 1'b0;
            cnt_d    = '0;
            addr_d   = bus_io.if_addr;
            read_n_d = 1'b0;
          end
        end
      end
      StAccess: begin
        // The memory completed the access at this cycle's falling edge.
        if (!we_q) begin
          if (win_dp_q) dp_rdata_d = bus_io.mem_out;
          else          if_rdata_d = bus_io.mem_out;
        end
        dp_ack_d = win_dp_q;
        if_ack_d = ~win_dp_q;
        if (cnt_q == '0) begin
          dp_done_d = win_dp_q;
          state_d   = StIdle;
        end else begin
          cnt_d   = cnt_q - LW'(1);
          state_d = StNext;
        end
      end
      StNext: begin
        addr_d  = addr_q + AW'(1);
        wdata_d = bus_io.dp_wdata;
        if (we_q) write_n_d = 1'b0;
        else      read_n_d  = 1'b0;
        state_d = StAccess;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers. A synchronous reset discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q    <= StIdle;
      win_dp_q   <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_n_q  <= 1'b1;
      read_n_q   <= 1'b1;
      if_ack_q   <= 1'b0;
      dp_ack_q   <= 1'b0;
      dp_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_dp_q   <= win_dp_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_n_q  <= write_n_d;
      read_n_q   <= read_n_d;
      if_ack_q   <= if_ack_d;
      dp_ack_q   <= dp_ack_d;
      dp_done_q  <= dp_done_d;
      if_rdata_q <= if_rdata_d;
      dp_rdata_q <= dp_rdata_d;
    end
  end

  assign bus_io.if_ack      = if_ack_q;
  assign bus_io.if_rdata    = if_rdata_q;
  assign bus_io.dp_ack      = dp_ack_q;
  assign bus_io.dp_rdata    = dp_rdata_q;
  assign bus_io.dp_done     = dp_done_q;
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.mem_addr    = addr_q;
  assign bus_io.mem_in      = wdata_q;
  assign bus_io.mem_write_n = write_n_q;
  assign bus_io.mem_read_n  = read_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter. A transaction-level
// model schedules the expected strobes, acks, busy and read data for every cycle. A
// behavioural memory sits on the memory side.
module tb_mem_arbiter;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic proc_rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(6), .DW(16), .LW(3)) bus ();

  mem_arbiter #(.AW(6), .DW(16), .LW(3)) dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus_io   (bus.slave)
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 5) return 16'h1D29;
    return 16'(i * 797 + 961);
  endfunction

  // Memory environment: acts on the falling edge, as the real block does.
  logic [15:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    bus.mem_out = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_write_n === 1'b0) mem[bus.mem_addr] = bus.mem_in;
      if (bus.mem_read_n === 1'b0) bus.mem_out = mem[bus.mem_addr];
    end
  end

  // Reference model state.
  typedef struct {int cyc; int addr;} pend_t;
  pend_t       pend_q[$];
  logic [15:0] ref_mem [64];
  bit          e_if_ack [MAXC];
  bit          e_dp_ack [MAXC];
  bit          e_done [MAXC];
  bit          e_busy [MAXC];
  bit          e_wstb [MAXC];
  bit          e_rstb [MAXC];
  bit          e_rdv [MAXC];
  logic [15:0] e_rd [MAXC];
  int          e_addr [MAXC];
  logic [15:0] held_if, held_dp;
  int          idle_at;
  int          cyc;
  int          n_checks, n_bad;
`ifdef MEM_ARB_RR_EN
  bit          last_dp;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    if (e_rdv[cyc]) begin
      if (e_if_ack[cyc]) held_if = e_rd[cyc];
      else               held_dp = e_rd[cyc];
    end
    check_eq("if_ack", 32'(bus.if_ack), 32'(e_if_ack[cyc]));
    check_eq("dp_ack", 32'(bus.dp_ack), 32'(e_dp_ack[cyc]));
    check_eq("dp_done", 32'(bus.dp_done), 32'(e_done[cyc]));
    check_eq("busy", 32'(bus.busy), 32'(e_busy[cyc]));
    check_eq("write_n", 32'(bus.mem_write_n), 32'(!e_wstb[cyc]));
    check_eq("read_n", 32'(bus.mem_read_n), 32'(!e_rstb[cyc]));
    if (e_wstb[cyc] || e_rstb[cyc]) check_eq("mem_addr", 32'(bus.mem_addr), 32'(e_addr[cyc]));
    check_eq("if_rdata", 32'(bus.if_rdata), 32'(held_if));
    check_eq("dp_rdata", 32'(bus.dp_rdata), 32'(held_dp));
  endtask

  task automatic model_step(input bit rst, input bit ifr, input int ifa, input bit dpr,
                            input bit we, input int da, input int dl, input logic [15:0] wd);
    bit if_el, dp_el, take_dp;
    int n, base, a, t;
    if (rst) begin
      for (int i = cyc + 1; i <= cyc + 20; i++) begin
        e_if_ack[i] = 0; e_dp_ack[i] = 0; e_done[i] = 0; e_busy[i] = 0;
        e_wstb[i] = 0; e_rstb[i] = 0; e_rdv[i] = 0;
      end
      pend_q.delete();
      idle_at = cyc + 1;
      held_if = '0;
      held_dp = '0;
`ifdef MEM_ARB_RR_EN
      last_dp = 1'b1;
`endif
      return;
    end
    if (cyc >= idle_at) begin
      if_el = ifr && !e_if_ack[cyc];
      dp_el = dpr && !e_done[cyc];
      if (if_el || dp_el) begin
`ifdef MEM_ARB_RR_EN
        take_dp = dp_el && (!if_el || !last_dp);
        last_dp = take_dp;
`else
        take_dp = dp_el;
`endif
        n    = take_dp ? dl + 1 : 1;
        base = take_dp ? da : ifa;
        for (int k = 1; k <= n; k++) begin
          a = (base + k - 1) % 64;
          t = cyc + 2 * k - 1;
          e_addr[t] = a;
          e_busy[t] = 1;
          if (k < n) e_busy[t + 1] = 1;
          if (take_dp && we) begin
            e_wstb[t] = 1;
            pend_q.push_back('{cyc: t - 1, addr: a});
          end else begin
            e_rstb[t]    = 1;
            e_rdv[t + 1] = 1;
            e_rd[t + 1]  = ref_mem[a];
          end
          if (take_dp) e_dp_ack[t + 1] = 1;
          else         e_if_ack[t + 1] = 1;
        end
        if (take_dp) e_done[cyc + 2 * n] = 1;
        idle_at = cyc + 2 * n;
      end
    end
    // Write data presented this cycle reaches memory in the next (strobe) cycle.
    while (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
      ref_mem[pend_q[0].addr] = wd;
      void'(pend_q.pop_front());
    end
  endtask

  task automatic tick(input bit rst, input bit ifr, input int ifa, input bit dpr,
                      input bit we, input int da, input int dl);
    logic [15:0] wd;
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    wd           = 16'($urandom);
    proc_rst     = rst;
    bus.if_req   = ifr;
    bus.if_addr  = 6'(ifa);
    bus.dp_req   = dpr;
    bus.dp_we    = we;
    bus.dp_addr  = 6'(da);
    bus.dp_len   = 3'(dl);
    bus.dp_wdata = wd;
    model_step(rst, ifr, ifa, dpr, we, da, dl, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nbusy;
    n_checks = 0;
    n_bad    = 0;
    cyc      = 0;
    idle_at  = 0;
    held_if  = '0;
    held_dp  = '0;
`ifdef MEM_ARB_RR_EN
    last_dp  = 1'b1;
`endif
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    bus.if_req = 0; bus.if_addr = 0; bus.dp_req = 0; bus.dp_we = 0;
    bus.dp_addr = 0; bus.dp_len = 0; bus.dp_wdata = 0;

    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_in", 32'(bus.mem_in), 32'd0);

    // Single fetch from address 5.
    tick(0, 1, 5, 0, 0, 0, 0);
    idle(4);
    check_eq("fetch_word", 32'(bus.if_rdata), 32'h1D29);

    // Three-beat write burst wrapping past address 63.
    tick(0, 0, 0, 1, 1, 62, 2);
    idle(8);

    // Eight-beat read burst from address 2.
    nbusy = 0;
    tick(0, 0, 0, 1, 0, 2, 7);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (bus.busy) nbusy++;
    end
    check_eq("busy_cycles", 32'(nbusy), 32'd15);

    // Fetch, then both ports held for several grants.
    tick(0, 1, 9, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 7; i++) tick(0, 1, 12, 1, 0, 30, 0);
    idle(3);

    // Reset during the strobe cycle of beat 2 of a write burst at 20.
    tick(0, 0, 0, 1, 1, 20, 2);
    idle(2);
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(6);
    check_eq("rst_beat3", 32'(mem[22]), 32'(init_word(22)));

    // Data request held through dp_done with a single beat.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0, 40, 0);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      tick(($urandom % 200) == 0, ($urandom % 3) == 0, int'($urandom % 64),
           ($urandom % 5) < 2, $urandom % 2 == 1, int'($urandom % 64), int'($urandom % 8));
    end
    idle(20);

    for (int i = 0; i < 64; i++) check_eq("mem_word", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
